pc_next_unit: RTL

PC_NEXT_UNIT -- requirements
Module: pc_next_unit

---
 rtl/mips_pkg.sv | 25 ++
 rtl/pc_next_unit_if.sv | 27 ++
 rtl/pc_target_calc.sv | 26 ++
 rtl/pc_next_unit.sv | 117 +++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared types and constants for the PC sequencing logic.
// Optional feature macro: BRANCH_DELAY_SLOT_EN (delay-slot redirect semantics).
package mips_pkg;

    localparam int unsigned ADDR_W = 8;
    localparam int unsigned CNT_W  = 16;
    localparam int unsigned IMM_W  = 32;
    localparam int unsigned JV_W   = 26;
    localparam int unsigned OFS_W  = 6;

    localparam logic [ADDR_W-1:0] IMEM_LAST_ADDR = 8'h7C;
    localparam logic [ADDR_W-1:0] PC_STEP        = 8'd4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } pc_state_t;

    // Saturating increment for the issued-instruction counter.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
    endfunction

endpackage

// File: rtl/pc_next_unit_if.sv
// Core-side control/status bundle of the PC sequencing unit.
interface pc_next_unit_if;
    import mips_pkg::*;

    logic              start;
    logic              stall;
    logic              halt;
    logic              zero;
    logic              branch;
    logic              jump;
    logic [IMM_W-1:0]  seimm;
    logic [JV_W-1:0]   jump_value;
    logic [ADDR_W-1:0] read_addr;
    logic              running;
    logic              halted;
    logic [CNT_W-1:0]  inst_count;

    modport master (
        output start, stall, halt, zero, branch, jump, seimm, jump_value,
        input  read_addr, running, halted, inst_count
    );

    modport slave (
        input  start, stall, halt, zero, branch, jump, seimm, jump_value,
        output read_addr, running, halted, inst_count
    );
endinterface

// File: rtl/pc_target_calc.sv
// Combinational candidate-address generation: sequential, branch and jump.
module pc_target_calc
    import mips_pkg::*;
(
    input  logic [ADDR_W-1:0] read_addr,
    input  logic              branch,
    input  logic              zero,
    input  logic              jump,
    input  logic [OFS_W-1:0]  imm_ofs,
    input  logic [OFS_W-1:0]  jump_ofs,
    output logic [ADDR_W-1:0] seq_addr_c,
    output logic              redir_c,
    output logic [ADDR_W-1:0] redir_addr_c
);

    // Jump outranks a taken branch; all sums wrap in 8 bits.
    always_comb begin
        seq_addr_c   = read_addr + PC_STEP;
        redir_c      = jump | (branch & zero);
        redir_addr_c = seq_addr_c + ADDR_W'({imm_ofs, 2'b00});
        if (jump) begin
            redir_addr_c = ADDR_W'({jump_ofs, 2'b00});
        end
    end

endmodule

// File: rtl/pc_next_unit.sv
// Fetch-address sequencer: IDLE/RUN/HALT control, PC register, issue counter.
// Optional feature macro: BRANCH_DELAY_SLOT_EN (redirect takes effect after one delay slot).
module pc_next_unit
    import mips_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    pc_next_unit_if.slave bus
);

    pc_state_t         state;
    logic [ADDR_W-1:0] read_addr;
    logic [CNT_W-1:0]  inst_count;
    logic              running;
    logic              halted;

    logic [ADDR_W-1:0] seq_addr_c;
    logic              redir_c;
    logic [ADDR_W-1:0] redir_addr_c;
    logic [ADDR_W-1:0] next_addr_c;
    logic              advance_c;
    logic              stop_c;

    // Only the low offset bits of the immediate and jump field address the 128-byte IMEM.
    wire unused_bits = ^{bus.seimm[IMM_W-1:OFS_W], bus.jump_value[JV_W-1:OFS_W]};

    pc_target_calc u_calc (
        .read_addr    (read_addr),
        .branch       (bus.branch),
        .zero         (bus.zero),
        .jump         (bus.jump),
        .imm_ofs      (bus.seimm[OFS_W-1:0]),
        .jump_ofs     (bus.jump_value[OFS_W-1:0]),
        .seq_addr_c   (seq_addr_c),
        .redir_c      (redir_c),
        .redir_addr_c (redir_addr_c)
    );

`ifdef BRANCH_DELAY_SLOT_EN
    logic              pend_valid;
    logic [ADDR_W-1:0] pend_addr;

    // Pending redirect wins; otherwise the delay slot fetches sequentially.
    always_comb begin
        next_addr_c = pend_valid ? pend_addr : seq_addr_c;
    end
`else
    // Redirect is applied on the very next edge.
    always_comb begin
        next_addr_c = redir_c ? redir_addr_c : seq_addr_c;
    end
`endif

    // Halt request or an out-of-range target stops fetching; otherwise advance unless stalled.
    always_comb begin
        stop_c    = (state == ST_RUN) &
                    (bus.halt | (~bus.stall & (next_addr_c > IMEM_LAST_ADDR)));
        advance_c = (state == ST_RUN) & ~bus.stall & ~stop_c;
    end

`ifdef BRANCH_DELAY_SLOT_EN
    // Latch a redirect target; control inputs seen during the delay slot are ignored.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pend_valid <= 1'b0;
            pend_addr  <= '0;
        end else if ((state != ST_RUN) || stop_c) begin
            pend_valid <= 1'b0;
        end else if (advance_c) begin
            pend_valid <= redir_c & ~pend_valid;
            if (redir_c && !pend_valid) begin
                pend_addr <= redir_addr_c;
            end
        end
    end
`endif

    // Control FSM with PC and issue counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            read_addr  <= '0;
            inst_count <= '0;
            running    <= 1'b0;
            halted     <= 1'b0;
        end else begin
            case (state)
                ST_RUN: begin
                    if (stop_c) begin
                        state   <= ST_HALT;
                        running <= 1'b0;
                        halted  <= 1'b1;
                    end else if (advance_c) begin
                        read_addr  <= next_addr_c;
                        inst_count <= sat_inc(inst_count);
                    end
                end
                default: begin
                    if (bus.start) begin
                        state      <= ST_RUN;
                        read_addr  <= '0;
                        inst_count <= '0;
                        running    <= 1'b1;
                        halted     <= 1'b0;
                    end
                end
            endcase
        end
    end

    // Registered status to the core.
    assign bus.read_addr  = read_addr;
    assign bus.inst_count = inst_count;
    assign bus.running    = running;
    assign bus.halted     = halted;

endmodule
